// File: rtl/openhw_fdivsqrtseq.sv
// -----------------------------------------------------------------------------
// openhw_fdivsqrtseq
//
// Sequencing controller for the iterative divide / square-root digit
// recurrence. It turns a start request from the execute stage into a one-cycle
// load pulse and a register enable for the residual, U/UM and C registers. It
// counts the remaining iterations, bypasses special cases, terminates early on
// a zero residual, and holds the result while the downstream stage is stalled.
//
// Handshake: a start is taken only when FDivStartE is high in IDLE with no
// stall and no flush (IFDivStartE). The result is offered with FDivDoneE for as
// long as the block sits in DONE. DONE is left on the first cycle with StallM
// low, or at once on FlushE.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   FDivStartE        execute stage requests an operation
//   SpecialCaseE      result known without iterating (valid with FDivStartE)
//   CyclesE           recurrence cycles required (valid with FDivStartE)
//   WZeroE            residual is zero, ends the recurrence early
//   StallM            downstream stall: blocks a start and holds DONE
//   FlushE            kills the in-flight operation
//   IFDivStartE       one-cycle load pulse to the datapath init muxes
//   FDivBusyE         datapath register enable, also stalls the pipeline
//   FDivDoneE         result ready for postprocessing
//   SpecialCaseLatE   SpecialCaseE captured at the last accepted start
//   CountE            remaining iterations
//   state_dbg         current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// -----------------------------------------------------------------------------
module openhw_fdivsqrtseq #(
    parameter int CNTW = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            FDivStartE,
    input  logic            SpecialCaseE,
    input  logic [CNTW-1:0] CyclesE,
    input  logic            WZeroE,
    input  logic            StallM,
    input  logic            FlushE,
    output logic            IFDivStartE,
    output logic            FDivBusyE,
    output logic            FDivDoneE,
    output logic            SpecialCaseLatE,
    output logic [CNTW-1:0] CountE,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CNTW-1:0] count;

    localparam logic [CNTW-1:0] ONE = {{(CNTW-1){1'b0}}, 1'b1};

    // The reset term keeps every output low while reset is held, even if a
    // start request is already present on the inputs.
    assign IFDivStartE = FDivStartE & (state == IDLE) & ~StallM & ~FlushE & ~reset;

    // Registers load on the start cycle and update on every BUSY cycle.
    assign FDivBusyE   = (state == BUSY) | IFDivStartE;
    assign FDivDoneE   = (state == DONE);
    assign CountE      = count;
    assign state_dbg   = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            count           <= '0;
            SpecialCaseLatE <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (IFDivStartE) begin
                        SpecialCaseLatE <= SpecialCaseE;
                        if (SpecialCaseE) begin
                            // Bypass: the counter is left untouched.
                            state <= DONE;
                        end else begin
                            state <= BUSY;
                            // A zero cycle request still runs one iteration.
                            count <= (CyclesE == '0) ? ONE : CyclesE;
                        end
                    end
                end
                BUSY: begin
                    if (FlushE) begin
                        state <= IDLE;
                        count <= '0;
                    end else if ((count == ONE) || WZeroE) begin
                        state <= DONE;
                        count <= '0;
                    end else if (count != '0) begin
                        // Saturating decrement, never wraps below zero.
                        count <= count - ONE;
                    end
                end
                DONE: begin
                    if (FlushE || !StallM) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule
